// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Handshake bundle for the pipelined immediate generator.
//               It carries the input side (instruction bits, format select,
//               tag), the output side (immediate, illegal flag, tag) and flush.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // Decode-stage side that issues instructions and consumes immediates
    modport master (
        output flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    // Immediate generator side
    modport slave (
        input  flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator with a 2-entry skid buffer.
//               The immediate is extended combinationally from the incoming
//               instruction bits, then registered into a main/skid pair so
//               that in_ready is a pure register output.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Instruction bits keep their architectural indices [31:7]
    logic [31:7]        w_ir;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic               w_in_xfer;
    logic               w_out_xfer;

    state_t             r_state;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [XLEN-1:0]    r_main_imm;
    logic               r_main_ill;
    logic [TAG_W-1:0]   r_main_tag;
    logic [XLEN-1:0]    r_skid_imm;
    logic               r_skid_ill;
    logic [TAG_W-1:0]   r_skid_tag;

    assign w_ir = bus.in_instr;

    // Build every format as a 32-bit signed value; zimm has bit 31 clear so
    // the final sign-extending cast to XLEN zero-extends it.
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (bus.in_imm_src)
            3'd0: w_imm32 = {{20{w_ir[31]}}, w_ir[31:20]};
            3'd1: w_imm32 = {{20{w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
            3'd2: w_imm32 = {{19{w_ir[31]}}, w_ir[31], w_ir[7], w_ir[30:25],
                             w_ir[11:8], 1'b0};
            3'd3: w_imm32 = {{11{w_ir[31]}}, w_ir[31], w_ir[19:12], w_ir[20],
                             w_ir[30:21], 1'b0};
            3'd4: w_imm32 = {w_ir[31:12], 12'd0};
            3'd5: w_imm32 = {27'd0, w_ir[19:15]};
            default: begin
                w_imm32   = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm      = XLEN'(w_imm32);
    assign w_in_xfer  = bus.in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;

    // Main/skid occupancy machine; rst and flush both drop every entry
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_imm  <= '0;
            r_main_ill  <= 1'b0;
            r_main_tag  <= '0;
            r_skid_imm  <= '0;
            r_skid_ill  <= 1'b0;
            r_skid_tag  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_imm  <= w_imm;
                        r_main_ill  <= w_illegal;
                        r_main_tag  <= bus.in_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_imm <= w_imm;
                        r_main_ill <= w_illegal;
                        r_main_tag <= bus.in_tag;
                    end else if (w_in_xfer) begin
                        // Main is stalled: park the new entry in the skid
                        r_skid_imm <= w_imm;
                        r_skid_ill <= w_illegal;
                        r_skid_tag <= bus.in_tag;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        r_main_imm <= r_skid_imm;
                        r_main_ill <= r_skid_ill;
                        r_main_tag <= r_skid_tag;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_main_imm;
    assign bus.out_illegal = r_main_ill;
    assign bus.out_tag     = r_main_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe. A 32-bit and a 64-bit
//               instance run in lockstep from the same stimulus; a scoreboard
//               queue holds the expected output of every accepted entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_ready = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;
    int   stalls = 0;
    exp_t sbq[$];

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    assign b64.flush      = b32.flush;
    assign b64.in_valid   = b32.in_valid;
    assign b64.in_instr   = b32.in_instr;
    assign b64.in_imm_src = b32.in_imm_src;
    assign b64.in_tag     = b32.in_tag;
    assign b64.out_ready  = b32.out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference extender written from the format table
    function automatic logic [63:0] gold(input logic [31:0] ins, input logic [2:0] src, input bit x64);
        logic [63:0] v;
        case (src)
            3'd0: v = 64'($signed(ins[31:20]));
            3'd1: v = 64'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd4: v = 64'($signed({ins[31:12], 12'h000}));
            3'd5: v = 64'(ins[19:15]);
            default: v = 64'd0;
        endcase
        return x64 ? v : {32'd0, v[31:0]};
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
        b32.in_valid   = 1'b1;
        b32.in_instr   = ins[31:7];
        b32.in_imm_src = src;
        b32.in_tag     = tag;
    endtask

    task automatic push(input logic [31:0] e32, input logic [63:0] e64, input logic ill, input logic [4:0] tag);
        exp_t e;
        e.e32 = e32; e.e64 = e64; e.ill = ill; e.tag = tag;
        sbq.push_back(e);
    endtask

    // Offer one entry, wait (bounded) for in_ready, record the expectation
    task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag,
                         input logic [31:0] e32, input logic [63:0] e64, input logic ill);
        int waited = 0;
        @(negedge clk);
        apply(ins, src, tag);
        while (!b32.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        stalls += waited;
        if (!b32.in_ready) begin
            nvec++; nfail++;
            $display("FAIL in_ready_timeout: in_ready %b after %0d cycles, want 1", b32.in_ready, waited);
        end else begin
            push(e32, e64, ill, tag);
        end
        @(posedge clk);
    endtask

    task automatic dgold(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tag);
        drive(ins, src, tag, gold(ins, src, 1'b0)[31:0], gold(ins, src, 1'b1), src >= 3'd6);
    endtask

    task automatic idle();
        @(negedge clk);
        b32.in_valid = 1'b0;
    endtask

    // Random backpressure during the streaming phase
    always @(negedge clk) begin
        if (rand_ready) b32.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pop and compare on every output transfer
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && b32.out_valid && b32.out_ready) begin
            if (sbq.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL unexpected_out: tag %h imm %h, want no output", b32.out_tag, b32.out_imm);
            end else begin
                e = sbq.pop_front();
                check("imm32",   64'(b32.out_imm), 64'(e.e32));
                check("imm64",   b64.out_imm, e.e64);
                check("illegal", 64'(b32.out_illegal), 64'(e.ill));
                check("tag",     64'(b32.out_tag), 64'(e.tag));
                check("valid64", 64'(b64.out_valid), 64'd1);
            end
        end
    end

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("FAIL watchdog: sequence still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic drop_test(input bit use_rst);
        int budget;
        idle();
        budget = 0;
        while (sbq.size() != 0 && budget < 100) begin @(negedge clk); budget++; end
        b32.out_ready = 1'b0;
        apply(32'hFFF00093, 3'd0, 5'h11);
        @(negedge clk);
        apply(32'hFE000EE3, 3'd2, 5'h12);
        @(negedge clk);
        check("drop_full_ready", 64'(b32.in_ready), 64'd0);
        check("drop_full_valid", 64'(b32.out_valid), 64'd1);
        apply(32'h800000B7, 3'd4, 5'h13);
        if (use_rst) rst = 1'b1; else b32.flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        check("drop_valid", 64'(b32.out_valid), 64'd0);
        check("drop_ready", 64'(b32.in_ready), 64'd1);
        if (use_rst) begin
            check("rst_imm32", 64'(b32.out_imm), 64'd0);
            check("rst_imm64", b64.out_imm, 64'd0);
            check("rst_tag",   64'(b32.out_tag), 64'd0);
        end
        b32.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("drop_stays_empty", 64'(b32.out_valid), 64'd0);
    endtask

    initial begin
        b32.flush = 1'b0;
        b32.out_ready = 1'b1;
        // A handshake offered during reset must be ignored
        apply(32'hFFF00093, 3'd0, 5'h1F);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(b32.out_valid), 64'd0);
        check("reset_in_ready",  64'(b32.in_ready), 64'd1);
        check("reset_imm",       64'(b32.out_imm), 64'd0);
        check("reset_illegal",   64'(b32.out_illegal), 64'd0);
        check("reset_tag",       64'(b32.out_tag), 64'd0);

        // Directed vectors with hand-computed immediates (32-bit and 64-bit)
        drive(32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        drive(32'h7FF00013, 3'd0, 5'd2,  32'h000007FF, 64'h00000000_000007FF, 1'b0);
        drive(32'hFE112E23, 3'd1, 5'd3,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        drive(32'hFE000EE3, 3'd2, 5'd4,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        drive(32'h0080006F, 3'd3, 5'd5,  32'h00000008, 64'h00000000_00000008, 1'b0);
        drive(32'h123450B7, 3'd4, 5'd6,  32'h12345000, 64'h00000000_12345000, 1'b0);
        drive(32'h800000B7, 3'd4, 5'd7,  32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
        drive(32'h000F8073, 3'd5, 5'd8,  32'h0000001F, 64'h00000000_0000001F, 1'b0);
        drive(32'hFFFFFFFF, 3'd5, 5'd9,  32'h0000001F, 64'h00000000_0000001F, 1'b0);
        drive(32'hFFFFFFFF, 3'd6, 5'h15, 32'h00000000, 64'h00000000_00000000, 1'b1);
        drive(32'hFFFFFFFF, 3'd7, 5'h0A, 32'h00000000, 64'h00000000_00000000, 1'b1);
        idle();
        repeat (3) @(negedge clk);

        // Full throughput when both sides are always ready
        stalls = 0;
        for (int i = 0; i < 8; i++) dgold(32'h00100093 + (i << 20), 3'd0, 5'(i));
        check("stream_stalls", 64'(stalls), 64'd0);
        idle();
        repeat (3) @(negedge clk);

        // Backpressure: tags 1,2 accepted, 3 held, then drained with no bubble
        b32.out_ready = 1'b0;
        apply(32'h00100093, 3'd0, 5'd1);
        check("bp_ready_t1", 64'(b32.in_ready), 64'd1);
        push(32'd1, 64'd1, 1'b0, 5'd1);
        @(negedge clk);
        apply(32'h00200093, 3'd0, 5'd2);
        check("bp_ready_t2", 64'(b32.in_ready), 64'd1);
        push(32'd2, 64'd2, 1'b0, 5'd2);
        @(negedge clk);
        apply(32'h00300093, 3'd0, 5'd3);
        check("bp_ready_full", 64'(b32.in_ready), 64'd0);
        check("bp_tag_held", 64'(b32.out_tag), 64'd1);
        @(negedge clk);
        check("bp_ready_full2", 64'(b32.in_ready), 64'd0);
        check("bp_imm_stable", 64'(b32.out_imm), 64'd1);
        check("bp_tag_stable", 64'(b32.out_tag), 64'd1);
        b32.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_drain", 64'(b32.in_ready), 64'd1);
        check("bp_tag2_next", 64'(b32.out_tag), 64'd2);
        push(32'd3, 64'd3, 1'b0, 5'd3);
        @(negedge clk);
        b32.in_valid = 1'b0;
        check("bp_valid3", 64'(b32.out_valid), 64'd1);
        check("bp_tag3_next", 64'(b32.out_tag), 64'd3);
        @(negedge clk);
        check("bp_empty", 64'(b32.out_valid), 64'd0);

        // Random stream with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            dgold($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        idle();
        rand_ready = 1'b0;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        check("stream_drained", 64'(sbq.size()), 64'd0);

        // Flush then reset from the FULL state with an incoming entry
        drop_test(1'b0);
        dgold(32'h123450B7, 3'd4, 5'h1C);
        drop_test(1'b1);
        dgold(32'hFE000EE3, 3'd2, 5'h1D);
        idle();
        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage of the RVSCC pipelined core. It accepts instruction bits and an immediate-type selector over a valid/ready handshake. It produces the XLEN-wide extended immediate one cycle later through a 2-entry skid buffer. Compared with the single-cycle combinational extender, it adds XLEN generalisation, U and CSR-zimm formats, illegal-selector flagging, a sideband tag, backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all sign extension fills to XLEN.
TAG_W, 5, width of the opaque sideband tag (e.g. rd or ROB index); carried alongside the immediate unchanged.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  drop all buffered entries (branch mispredict / trap)
in_valid  in  1  input entry present
in_ready  out  1  block can accept an entry
in_instr  in  25  instruction bits [31:7]
in_imm_src  in  3  immediate format select
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output entry present
out_ready  in  1  downstream accepts the entry
out_imm  out  XLEN  extended immediate
out_illegal  out  1  the entry had an unsupported in_imm_src
out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Format encoding (sext = sign-extend from instr[31] to XLEN):
  - 0 I: sext(instr[31:20])
  - 1 S: sext({instr[31:25], instr[11:7]})
  - 2 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 3 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 4 U: sext({instr[31:12], 12'b0})
  - 5 Z: zero-extended instr[19:15] (CSR zimm)
  - 6, 7: imm = 0, illegal = 1. All other formats: illegal = 0.
- Extension is combinational on the input side. The result is registered, so latency is exactly 1 cycle from the input handshake to out_valid when the buffer is empty.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_imm, out_illegal and out_tag are held stable while out_valid && !out_ready.
- Storage is a main register plus a skid register. Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, skid empty, in_ready=1.
  - FULL: both valid, in_ready=0.
- State transitions:
  - EMPTY + in-xfer -> ONE.
  - ONE + in-xfer + out-xfer -> ONE (main reloaded; 1 entry/cycle throughput).
  - ONE + in-xfer, no out-xfer -> FULL (entry goes to skid).
  - ONE + out-xfer only -> EMPTY.
  - FULL + out-xfer -> ONE (skid moves to main).
  - No input transfer can occur in FULL.
- in_ready is a registered signal: it depends only on skid occupancy, never combinationally on out_ready.
- Ordering is strictly FIFO.
- flush: next cycle both entries are invalid (state EMPTY). An input transfer in the flush cycle is discarded. An output transfer in the flush cycle still counts as consumed. in_ready=1 the cycle after flush.
- Reset:
  - out_valid=0, in_ready=1 from the first cycle after rst deasserts.
  - out_imm=0, out_illegal=0, out_tag=0, skid register cleared.
  - Handshakes while rst=1 are ignored.
  - rst asserted mid-operation drops all entries exactly like flush.
- Simultaneous flush and rst: same result (reset wins, identical state).
- XLEN=64: U and I sign-extend through bit 63. A non-legal XLEN is a compile-time assertion failure.

Test Plan:
- I and B formats, XLEN=32, out_ready=1:
  - instr 0xFFF00093, src 0 -> next cycle out_imm 0xFFFFFFFF, out_illegal 0.
  - instr 0xFE000EE3, src 2 -> out_imm 0xFFFFFFFC.
- U and Z formats:
  - XLEN=32: instr 0x123450B7, src 4 -> 0x12345000.
  - XLEN=64: instr 0x800000B7, src 4 -> 0xFFFFFFFF80000000.
  - Any XLEN: instr[19:15]=11111, src 5 -> 0x1F.
- Illegal selector: src 6 or 7 with instr 0xFFFFFFFF -> out_imm 0, out_illegal 1, tag passed through.
- Backpressure:
  - Setup: out_ready=0; offer tags 1, 2, 3 back-to-back.
  - Required: tags 1 and 2 accepted; in_ready=0 the cycle after tag 2; tag 3 held at input; out_imm stable.
  - Then out_ready=1 -> tags emerge 1, 2, 3 on consecutive cycles with no bubble after the stall clears.
- Streaming: 100 random entries, random in_valid/out_ready -> scoreboard matches the golden extender. Full throughput (1/cycle) whenever both sides are always ready.
- Flush and reset mid-operation:
  - FULL state + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and incoming entries never appear.
  - Same sequence with rst instead of flush -> identical result, out_imm=0.
